// File: rtl/data_mem_if_if.sv
// CPU-side and memory-side signal bundle for the data-memory access unit.
// master: the access unit itself; slave: the core/memory environment around it.
interface data_mem_if_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        cpu_done;
  logic        cpu_misalign;
  logic        cpu_timeout;
  logic [31:0] cpu_rdata;
  logic [1:0]  cpu_byte;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_stall, cpu_done, cpu_misalign, cpu_timeout, cpu_rdata, cpu_byte,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_stall, cpu_done, cpu_misalign, cpu_timeout, cpu_rdata, cpu_byte,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/data_mem_if.sv
// Multi-cycle data-memory access unit: alignment check, lane enables, write
// replication, bounded wait for mem_ack, and raw load-word capture.
//
// state | meaning
// IDLE  | waiting for cpu_req; alignment checked and request captured here
// REQ   | mem_req asserted, waiting for mem_ack or the wait limit
// DONE  | one-cycle cpu_done, core advances
// ERR   | one-cycle cpu_misalign or cpu_timeout, core advances
module data_mem_if #(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  data_mem_if_if.master    bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [7:0]  cnt;
  logic        err_to;
  logic [1:0]  byte_q;
  logic        misalign;
  logic [3:0]  be_nx;
  logic [31:0] wdata_nx;

  always_comb begin
    misalign = 1'b0;
    unique case (bus.cpu_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = bus.cpu_addr[0];
      2'b10:   misalign = (bus.cpu_addr[1:0] != 2'b00);
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    be_nx    = 4'b1111;
    wdata_nx = bus.cpu_wdata;
    unique case (bus.cpu_size)
      2'b00: begin
        wdata_nx = {4{bus.cpu_wdata[7:0]}};
        if (bus.cpu_we) be_nx = 4'b0001 << bus.cpu_addr[1:0];
      end
      2'b01: begin
        wdata_nx = {2{bus.cpu_wdata[15:0]}};
        if (bus.cpu_we) be_nx = bus.cpu_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.cpu_req) state_nx = misalign ? ERR : REQ;
      REQ: begin
        if (bus.mem_ack)          state_nx = DONE;
        else if (cnt == CNT_LAST) state_nx = ERR;
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.cpu_stall    = 1'b0;
    bus.cpu_done     = 1'b0;
    bus.cpu_misalign = 1'b0;
    bus.cpu_timeout  = 1'b0;
    unique case (state)
      IDLE:    bus.cpu_stall = bus.cpu_req && !rst;
      REQ:     bus.cpu_stall = !rst;
      DONE:    bus.cpu_done = 1'b1;
      ERR: begin
        bus.cpu_misalign = !err_to;
        bus.cpu_timeout  = err_to;
      end
      default: ;
    endcase
  end

  // Registered memory-side outputs stay frozen for the whole REQ phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      bus.cpu_rdata <= '0;
      bus.cpu_byte  <= '0;
      byte_q        <= '0;
      cnt           <= '0;
      err_to        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            err_to <= 1'b0;
            if (!misalign) begin
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= bus.cpu_we;
              bus.mem_addr  <= {bus.cpu_addr[31:2], 2'b00};
              bus.mem_be    <= be_nx;
              bus.mem_wdata <= wdata_nx;
              byte_q        <= bus.cpu_addr[1:0];
              cnt           <= '0;
            end
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            if (!bus.mem_we) begin
              bus.cpu_rdata <= bus.mem_rdata;
              bus.cpu_byte  <= byte_q;
            end
          end else if (cnt == CNT_LAST) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            err_to      <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_if.sv
// Directed plus randomized bench for data_mem_if against a behavioural
// model of alignment, lane enables, replication, latency and load capture.
module tb_data_mem_if;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_if_if bus ();
  data_mem_if #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  logic [31:0] m_rdata;
  logic [1:0]  m_byte;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic is_mis(input logic [1:0] size, input logic [31:0] addr);
    int n;
    if (size == 2'b11) return 1'b1;
    n = 1 << size;
    return (int'(addr[1:0]) % n) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic we, input logic [1:0] size, input logic [1:0] off);
    int n;
    if (!we) return 4'hf;
    n = 1 << size;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = 1 << size;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_stall"}, 32'(bus.cpu_stall), 32'd0);
    chk({tag, "_memreq"}, 32'(bus.mem_req), 32'd0);
    chk({tag, "_done"}, 32'(bus.cpu_done), 32'd0);
  endtask

  // One complete instruction; waits >= TO means mem_ack never comes.
  task automatic access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input int waits, input logic [31:0] rd);
    int k;
    logic acked;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_size  = size;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    bus.mem_ack   = 1'b0;
    #1;
    chk("stall_n", 32'(bus.cpu_stall), 32'd1);
    chk("memreq_n", 32'(bus.mem_req), 32'd0);
    step();
    if (is_mis(size, addr)) begin
      chk("misalign", 32'(bus.cpu_misalign), 32'd1);
      chk("mis_to", 32'(bus.cpu_timeout), 32'd0);
      chk("mis_done", 32'(bus.cpu_done), 32'd0);
      chk("mis_memreq", 32'(bus.mem_req), 32'd0);
      chk("mis_stall", 32'(bus.cpu_stall), 32'd0);
    end else begin
      acked = 1'b0;
      k = 0;
      while (k < TO && !acked) begin
        chk("req_memreq", 32'(bus.mem_req), 32'd1);
        chk("req_stall", 32'(bus.cpu_stall), 32'd1);
        chk("req_addr", bus.mem_addr, {addr[31:2], 2'b00});
        chk("req_be", 32'(bus.mem_be), 32'(exp_be(we, size, addr[1:0])));
        chk("req_we", 32'(bus.mem_we), 32'(we));
        if (we) chk("req_wdata", bus.mem_wdata, exp_wd(size, wd));
        acked = (k == waits);
        bus.mem_ack   = acked;
        bus.mem_rdata = rd;
        step();
        bus.mem_ack = 1'b0;
        k++;
      end
      if (acked) begin
        chk("done", 32'(bus.cpu_done), 32'd1);
        chk("done_to", 32'(bus.cpu_timeout), 32'd0);
        if (!we) begin
          m_rdata = rd;
          m_byte  = addr[1:0];
        end
      end else begin
        chk("timeout", 32'(bus.cpu_timeout), 32'd1);
        chk("to_done", 32'(bus.cpu_done), 32'd0);
        chk("to_mis", 32'(bus.cpu_misalign), 32'd0);
      end
      chk("end_stall", 32'(bus.cpu_stall), 32'd0);
      chk("end_memreq", 32'(bus.mem_req), 32'd0);
    end
    chk("rdata", bus.cpu_rdata, m_rdata);
    chk("byte", 32'(bus.cpu_byte), 32'(m_byte));
    // cpu_req is still high across the retiring edge and must be ignored.
    step();
    bus.cpu_req = 1'b0;
    #1;
    check_quiet("retire");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic we;
    logic [1:0] sz;
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_size = 2'b00;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    m_rdata = '0;
    m_byte  = '0;
    step();
    step();
    chk("rst_memreq", 32'(bus.mem_req), 32'd0);
    chk("rst_be", 32'(bus.mem_be), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_flags", {bus.cpu_done, bus.cpu_misalign, bus.cpu_timeout, bus.mem_we, bus.cpu_stall}, 32'd0);
    rst = 1'b0;
    step();

    access(1'b1, 2'b10, 32'h100, 32'h8040C0FF, 2, 32'h0);
    access(1'b0, 2'b00, 32'h101, 32'h0, 0, 32'h8040C0FF);
    access(1'b1, 2'b00, 32'h203, 32'h000000A5, 1, 32'h0);
    access(1'b1, 2'b01, 32'h302, 32'h1234BEEF, 0, 32'h0);
    access(1'b0, 2'b01, 32'h401, 32'h0, 0, 32'hDEADBEEF);
    access(1'b0, 2'b10, 32'h402, 32'h0, 0, 32'hDEADBEEF);
    access(1'b0, 2'b11, 32'h404, 32'h0, 0, 32'hDEADBEEF);
    access(1'b0, 2'b10, 32'h600, 32'h0, 99, 32'hCAFEF00D);
    access(1'b0, 2'b10, 32'h604, 32'h0, TO - 1, 32'h13572468);

    // mem_ack outside REQ
    bus.mem_ack = 1'b1;
    step();
    step();
    bus.mem_ack = 1'b0;
    #1;
    check_quiet("stray_ack");
    chk("stray_rdata", bus.cpu_rdata, m_rdata);

    // reset in the second REQ cycle of a load
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_size = 2'b10; bus.cpu_addr = 32'h704;
    step();
    chk("pre_rst_memreq", 32'(bus.mem_req), 32'd1);
    step();
    rst = 1'b1;
    #1;
    chk("mrst_memreq", 32'(bus.mem_req), 32'd0);
    chk("mrst_stall", 32'(bus.cpu_stall), 32'd0);
    chk("mrst_be", 32'(bus.mem_be), 32'd0);
    chk("mrst_addr", bus.mem_addr, 32'd0);
    chk("mrst_rdata", bus.cpu_rdata, 32'd0);
    chk("mrst_byte", 32'(bus.cpu_byte), 32'd0);
    m_rdata = '0;
    m_byte  = '0;
    bus.cpu_req = 1'b0;
    step();
    rst = 1'b0;
    step();
    access(1'b0, 2'b10, 32'h500, 32'h0, 1, 32'hA1B2C3D4);

    for (int i = 0; i < 30; i++) begin
      we = 1'($urandom);
      sz = 2'($urandom);
      access(we, sz, $urandom, $urandom, int'($urandom_range(0, 5)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_if.md
# data_mem_if

Multi-cycle data-memory access unit between the core's MEM stage and a variable-latency data memory. It checks alignment for byte, half and word accesses and stalls the core until the access completes. It drives a word-aligned request with byte-lane enables and replicated write data. For loads it captures the raw 32-bit memory word and the byte offset, and hands both to the downstream load extender, which performs lane selection and sign or zero extension.

## Interface
- TIMEOUT, 255: maximum REQ cycles without mem_ack before abort; range 1..255.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  memory instruction present in MEM; level, held until cpu_done or cpu_misalign/cpu_timeout.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, right-aligned.
- cpu_stall  out  1  freeze core pipeline.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_misalign  out  1  one-cycle alignment-fault pulse.
- cpu_timeout  out  1  one-cycle bus-timeout pulse.
- cpu_rdata  out  32  last captured load word, unshifted; feeds the extender's readdata.
- cpu_byte  out  2  captured addr[1:0]; feeds the extender's byte select.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  write strobe.
- mem_addr  out  32  {addr[31:2],2'b00}.
- mem_be  out  4  byte-lane enables.
- mem_wdata  out  32  lane-replicated write data.
- mem_ack  in  1  memory accepts/completes the access in this cycle; mem_rdata valid for reads.
- mem_rdata  in  32  read word.

## Operation
- FSM states: IDLE, REQ, DONE, ERR. Reset state is IDLE.
- **IDLE**
  - cpu_req=1 with a misaligned access → ERR (code misalign). Misaligned means:
    - half with addr[0]=1;
    - word with addr[1:0]≠0;
    - size 11.
  - cpu_req=1 with an aligned access → capture we, size, addr and wdata; clear the wait counter; go to REQ.
- **REQ**
  - mem_req=1; registered mem_* outputs are held constant.
  - mem_ack=1 → go to DONE. For a load, also latch cpu_rdata←mem_rdata and cpu_byte←addr[1:0].
  - No ack and counter==TIMEOUT−1 → go to ERR (code timeout).
  - Otherwise the counter increments.
  - An ack on the final counted cycle wins over the timeout.
- **DONE**: cpu_done=1 for one cycle, then IDLE.
- **ERR**: cpu_misalign or cpu_timeout=1 for one cycle, matching the captured code; then IDLE. No memory access is issued for a misalign.
- cpu_stall (combinational):
  - 1 in IDLE when cpu_req=1;
  - 1 in REQ;
  - 0 in DONE and ERR, so the core advances on that edge.
- cpu_req is sampled only in IDLE. A cpu_req seen in DONE or ERR belongs to the retiring instruction and is ignored.
- mem_be:
  - loads: 1111;
  - byte store: 0001<<addr[1:0];
  - half store: addr[1] ? 1100 : 0011;
  - word store: 1111.
- mem_wdata:
  - byte: {4{wdata[7:0]}};
  - half: {2{wdata[15:0]}};
  - word: wdata.
- Stores leave cpu_rdata and cpu_byte unchanged. Timeouts leave them unchanged.
- mem_ack outside REQ is ignored.

## Timing
- Reset values:
  - state IDLE;
  - cpu_done, cpu_misalign, cpu_timeout, mem_req, mem_we: 0;
  - mem_be: 0000;
  - mem_addr, mem_wdata, cpu_rdata: 0;
  - cpu_byte: 00;
  - counter: 0.
- Aligned access with ack in the first REQ cycle takes 3 cycles: request cycle N (IDLE, stall), N+1 (REQ, ack), N+2 (DONE). Each wait cycle adds 1.
- cpu_rdata is valid from cycle DONE onward and holds until the next load completes.
- Misaligned access: N (IDLE, stall), N+1 (ERR, pulse). mem_req is never asserted.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then ERR.
- Reset mid-REQ:
  - immediate return to IDLE; mem_req drops asynchronously;
  - the outstanding access is abandoned;
  - captured read data reverts to reset values.

## Test plan
- **lbu store/load**: sw 0x8040C0FF to 0x100 (ack after 2 waits), then lb at 0x101 (immediate ack, mem_rdata=0x8040C0FF).
  - Store: mem_be=1111, cpu_done at request+4.
  - Load: cpu_rdata=0x8040C0FF and cpu_byte=01 at request+2; stall high for cycles N and N+1 only.
- **sb replication**: sb wdata=0x000000A5 at 0x203 → mem_addr=0x200, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1.
- **sh lanes**: sh wdata=0x1234BEEF at 0x302 → mem_be=1100, mem_wdata=0xBEEFBEEF.
- **Misalign**: lh at 0x401, lw at 0x402, and size=11 → cpu_misalign pulse at N+1 in each case; mem_req never 1; cpu_rdata unchanged.
- **Timeout** (TIMEOUT=4), mem_ack held 0 → mem_req high exactly 4 cycles, cpu_timeout pulse in the next cycle, stall low in that cycle. A repeat with ack on the 4th cycle → cpu_done, no timeout.
- **Reset mid-access**: assert rst in the 2nd REQ cycle of a load → mem_req=0 and cpu_stall=0 immediately; all outputs at reset values. After release, an lw at 0x500 completes normally.
